// File: rtl/edge_pulse_gen.sv
//------------------------------------------------------------------------------
// Module   : edge_pulse_gen
// Brief    : Synchronises and debounces a raw level, then emits a one-cycle
//            Pulse on each accepted rising edge (and falling edge too when
//            EDGE_PULSE_BOTH_EN is defined).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module edge_pulse_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             In,
    output logic             Pulse,
    output logic             Level,
    output logic             Busy,
    output logic [CNT_W-1:0] Edge_cnt
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        ARM_HIGH    = 2'd1,
        STABLE_HIGH = 2'd2,
        ARM_LOW     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   pulse_q;
    logic                   pulse_d;
    logic [CNT_W-1:0]       edge_cnt_q;
    logic [CNT_W-1:0]       edge_cnt_d;
    logic                   s;
    logic                   qual_done;

    assign sync_d    = {sync_q[SYNC_STAGES-2:0], In};
    assign s         = sync_q[SYNC_STAGES-1];
    assign qual_done = (cnt_q == C_DEB_LIMIT);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q     <= '0;
            state_q    <= STABLE_LOW;
            cnt_q      <= '0;
            pulse_q    <= 1'b0;
            edge_cnt_q <= '0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pulse_q    <= pulse_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    // A reverting sample is tested before completion so that it wins a tie.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pulse_d    = 1'b0;
        edge_cnt_d = edge_cnt_q;
        case (state_q)
            STABLE_LOW: begin
                if (s) begin
                    state_d = ARM_HIGH;
                    cnt_d   = C_CNT_ONE;
                end
            end
            ARM_HIGH: begin
                if (!s) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (qual_done) begin
                    state_d    = STABLE_HIGH;
                    cnt_d      = '0;
                    pulse_d    = 1'b1;
                    edge_cnt_d = edge_cnt_q + C_CNT_ONE;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!s) begin
                    state_d = ARM_LOW;
                    cnt_d   = C_CNT_ONE;
                end
            end
            ARM_LOW: begin
                if (s) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (qual_done) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
`ifdef EDGE_PULSE_BOTH_EN
                    pulse_d    = 1'b1;
                    edge_cnt_d = edge_cnt_q + C_CNT_ONE;
`else
                    pulse_d    = 1'b0;
                    edge_cnt_d = edge_cnt_q;
`endif
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign Pulse    = pulse_q;
    assign Level    = (state_q == STABLE_HIGH) || (state_q == ARM_LOW);
    assign Busy     = (state_q == ARM_HIGH) || (state_q == ARM_LOW);
    assign Edge_cnt = edge_cnt_q;

endmodule

`default_nettype wire
